// File: rtl/b04_lbist_pkg.sv
// Shared types and constants for the b04 logic BIST controller.
// Holds the FSM encoding, LFSR polynomial, seed and step function.
package b04_lbist_pkg;

  localparam int SIG_W = 16;

  localparam logic [SIG_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [SIG_W-1:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_LAUNCH,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  // x^16+x^14+x^13+x^11+1, feedback enters bit 0
  function automatic logic [SIG_W-1:0] lfsr_step(
    input logic [SIG_W-1:0] v,
    input logic [1:0]       xin
  );
    logic [SIG_W-1:0] s;
    s    = {v[SIG_W-2:0], ^(v & LFSR_TAPS)};
    s[0] = s[0] ^ xin[0];
    s[8] = s[8] ^ xin[1];
    return s;
  endfunction

endpackage

// File: rtl/b04_lbist_lfsr.sv
// 16-bit Fibonacci LFSR with two serial XOR-in taps.
// Serves as pattern generator (xin tied low) or as MISR.
module b04_lbist_lfsr
  import b04_lbist_pkg::*;
#(
  parameter logic [SIG_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic [1:0]       xin,
  output logic [SIG_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= seed;
    end else if (en) begin
      q <= lfsr_step(q, xin);
    end
  end

endmodule

// File: rtl/b04_lbist_ctrl.sv
// LOC logic BIST controller for the b04 core: two scan chains,
// PRPG-driven loads and MISR compaction of the unloaded responses.
module b04_lbist_ctrl
  import b04_lbist_pkg::*;
#(
  parameter int CHAIN_LEN = 33,
  parameter int PATTERNS  = 256
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             start,
  input  logic [SIG_W-1:0] golden,
  output logic             test_se,
  output logic             test_si1,
  output logic             test_si2,
  input  logic             test_so1,
  input  logic             test_so2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  localparam int SW = $clog2(CHAIN_LEN);
  localparam int PW = $clog2(PATTERNS + 1);

  localparam logic [SW-1:0] SH_LAST  = SW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0] PAT_LAST = PW'(PATTERNS - 1);

  state_t           state;
  state_t           state_n;
  logic [SW-1:0]    sh_cnt;
  logic [PW-1:0]    pat_cnt;
  logic             go;
  logic             sh_last;
  logic             pat_last;
  logic             prpg_en;
  logic             misr_en;
  logic [SIG_W-1:0] prpg;
  logic [SIG_W-1:0] prpg_n;

  assign go       = start && (state == S_IDLE || state == S_DONE);
  assign sh_last  = (sh_cnt == SH_LAST);
  assign pat_last = (pat_cnt == PAT_LAST);
  assign prpg_en  = (state == S_SHIFT);

  // first load carries no response, so compaction starts at pattern 1
  assign misr_en = (state == S_SHIFT && pat_cnt != '0) ||
                   (state == S_UNLOAD);

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE,
      S_DONE:    if (go) state_n = S_SHIFT;
      S_SHIFT:   if (sh_last) state_n = S_LAUNCH;
      S_LAUNCH:  state_n = S_CAPTURE;
      S_CAPTURE: state_n = pat_last ? S_UNLOAD : S_SHIFT;
      S_UNLOAD:  if (sh_last) state_n = S_DONE;
      default:   state_n = S_IDLE;
    endcase
  end

  // value the PRPG will hold next cycle, so scan-in can be registered
  always_comb begin
    prpg_n = prpg;
    unique case (1'b1)
      go:      prpg_n = LFSR_SEED;
      prpg_en: prpg_n = lfsr_step(prpg, 2'b00);
      default: prpg_n = prpg;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      sh_cnt   <= '0;
      pat_cnt  <= '0;
      test_se  <= 1'b0;
      test_si1 <= 1'b0;
      test_si2 <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      test_se  <= (state_n == S_SHIFT) || (state_n == S_UNLOAD);
      busy     <= state_n inside {S_SHIFT, S_LAUNCH,
                                  S_CAPTURE, S_UNLOAD};
      done     <= (state_n == S_DONE);
      test_si1 <= (state_n == S_SHIFT) && prpg_n[0];
      test_si2 <= (state_n == S_SHIFT) && prpg_n[8];
      if (go) begin
        sh_cnt  <= '0;
        pat_cnt <= '0;
      end else begin
        if (state == S_SHIFT || state == S_UNLOAD) begin
          sh_cnt <= sh_last ? '0 : sh_cnt + SW'(1);
        end
        if (state == S_CAPTURE) begin
          pat_cnt <= pat_cnt + PW'(1);
        end
      end
    end
  end

  b04_lbist_lfsr #(
    .RST_VAL(LFSR_SEED)
  ) u_prpg (
    .clk  (CLOCK),
    .rst_n(RESET),
    .en   (prpg_en),
    .load (go),
    .seed (LFSR_SEED),
    .xin  (2'b00),
    .q    (prpg)
  );

  b04_lbist_lfsr #(
    .RST_VAL('0)
  ) u_misr (
    .clk  (CLOCK),
    .rst_n(RESET),
    .en   (misr_en),
    .load (go),
    .seed ('0),
    .xin  ({test_so2, test_so1}),
    .q    (signature)
  );

  assign pass = done && (signature == golden);

endmodule

// File: tb/tb_b04_lbist_ctrl.sv
// Bench for b04_lbist_ctrl: cycle-indexed reference model plus
// directed timing/signature pins and randomized scan responses.
module tb_b04_lbist_ctrl;

  localparam int CL    = 4;
  localparam int NP    = 2;
  localparam int NBUSY = NP * (CL + 2) + CL;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0;
  logic [15:0] golden = '0;
  logic        test_se;
  logic        test_si1;
  logic        test_si2;
  logic        test_so1 = 1'b0;
  logic        test_so2 = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  int total = 0;
  int bad = 0;
  int so_mode = 0;

  // model: mode 0 idle, 1 running (cycle m_k of the run), 2 done
  int          m_mode = 0;
  int          m_k = 0;
  logic [15:0] m_prpg = 16'hACE1;
  logic [15:0] m_misr = '0;

  b04_lbist_ctrl #(
    .CHAIN_LEN(CL),
    .PATTERNS (NP)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .start    (start),
    .golden   (golden),
    .test_se  (test_se),
    .test_si1 (test_si1),
    .test_si2 (test_si2),
    .test_so1 (test_so1),
    .test_so2 (test_so2),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .signature(signature)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [15:0] poly(input logic [15:0] v,
                                       input logic a,
                                       input logic b);
    logic fb;
    logic [15:0] r;
    fb = v[15] ^ v[13] ^ v[12] ^ v[10];
    r = {v[14:0], fb};
    r[0] = r[0] ^ a;
    r[8] = r[8] ^ b;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge CLOCK) begin : cmp
    int   p;
    int   off;
    logic sh;
    logic ul;
    p = 0;
    off = 0;
    sh = 1'b0;
    ul = 1'b0;
    if (!RESET) begin
      m_mode = 0;
      m_k = 0;
      m_prpg = 16'hACE1;
      m_misr = '0;
      chk("rst_se", test_se, 0);
      chk("rst_si", {test_si1, test_si2}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sig", signature, 0);
    end else begin
      if (m_mode == 1) begin
        p = (m_k - 1) / (CL + 2);
        off = (m_k - 1) % (CL + 2);
        if (p >= NP) ul = 1'b1;
        else if (off < CL) sh = 1'b1;
      end
      chk("se", test_se, sh | ul);
      chk("si1", test_si1, sh & m_prpg[0]);
      chk("si2", test_si2, sh & m_prpg[8]);
      chk("busy", busy, m_mode == 1);
      chk("done", done, m_mode == 2);
      chk("sig", signature, m_misr);
      chk("pass", pass, (m_mode == 2) && (m_misr == golden));
      if (m_mode != 1 && start) begin
        m_mode = 1;
        m_k = 1;
        m_prpg = 16'hACE1;
        m_misr = '0;
      end else if (m_mode == 1) begin
        if (sh) begin
          m_prpg = poly(m_prpg, 1'b0, 1'b0);
          if (p >= 1) m_misr = poly(m_misr, test_so1, test_so2);
        end
        if (ul) m_misr = poly(m_misr, test_so1, test_so2);
        m_k++;
        if (m_k > NBUSY) m_mode = 2;
      end
    end
  end

  initial begin : so_drv
    forever begin
      @(posedge CLOCK);
      #1;
      case (so_mode)
        0: begin test_so1 = 1'b0; test_so2 = 1'b0; end
        1: begin test_so1 = 1'b1; test_so2 = 1'b0; end
        default: {test_so2, test_so1} = 2'($urandom_range(0, 3));
      endcase
    end
  end

  task automatic pulse_start();
    @(posedge CLOCK);
    #1 start = 1'b1;
    @(posedge CLOCK);
    #1 start = 1'b0;
  endtask

  // called in the first busy cycle; returns in the cycle after busy falls
  task automatic run_wait(input bit poke, output int n,
                          output logic [15:0] se_h,
                          output logic [15:0] s1_h,
                          output logic [15:0] s2_h);
    n = 0;
    se_h = '0;
    s1_h = '0;
    s2_h = '0;
    while (busy && n < 1000) begin
      if (n < 16) begin
        se_h[n] = test_se;
        s1_h[n] = test_si1;
        s2_h[n] = test_si2;
      end
      n++;
      start = poke && (n == 3 || n == 7 || n == 16);
      @(posedge CLOCK);
      #1;
    end
    start = 1'b0;
    chk("run_bound", n < 1000, 1);
  endtask

  initial begin : main
    int n;
    logic [15:0] se_h;
    logic [15:0] s1_h;
    logic [15:0] s2_h;

    RESET = 1'b0;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("lit_rst_se", test_se, 0);
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_sig", signature, 16'h0000);
    RESET = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    chk("lit_idle_hold", {busy, done, test_se}, 0);

    so_mode = 0;
    golden = 16'h0000;
    pulse_start();
    chk("lit_first_busy", busy, 1);
    run_wait(1'b0, n, se_h, s1_h, s2_h);
    chk("lit_a_busy_cycles", n, 16);
    chk("lit_a_se_pattern", se_h, 16'b1111001111001111);
    chk("lit_a_si1_first", s1_h[1:0], 2'b11);
    chk("lit_a_si2_first", s2_h[1:0], 2'b10);
    chk("lit_a_si_launch", {s1_h[5:4], s2_h[5:4]}, 0);
    chk("lit_a_done", done, 1);
    chk("lit_a_sig", signature, 16'h0000);
    chk("lit_a_pass", pass, 1);
    @(posedge CLOCK);
    #1;
    chk("lit_a_done_held", done, 1);

    so_mode = 1;
    pulse_start();
    chk("lit_b_done_clr", done, 0);
    run_wait(1'b0, n, se_h, s1_h, s2_h);
    chk("lit_b_busy_cycles", n, 16);
    chk("lit_b_sig", signature, 16'h00FF);
    chk("lit_b_pass", pass, 0);

    pulse_start();
    chk("lit_c_done_clr", done, 0);
    run_wait(1'b1, n, se_h, s1_h, s2_h);
    chk("lit_c_busy_cycles", n, 16);
    chk("lit_c_se_pattern", se_h, 16'b1111001111001111);
    chk("lit_c_sig", signature, 16'h00FF);

    pulse_start();
    @(posedge CLOCK);
    @(posedge CLOCK);
    #3 RESET = 1'b0;
    #1;
    chk("lit_d_async_se", test_se, 0);
    chk("lit_d_async_busy", busy, 0);
    chk("lit_d_async_si", test_si1, 0);
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b1;
    pulse_start();
    run_wait(1'b0, n, se_h, s1_h, s2_h);
    chk("lit_e_busy_cycles", n, 16);
    chk("lit_e_sig", signature, 16'h00FF);
    chk("lit_e_si1_first", s1_h[1:0], 2'b11);

    so_mode = 2;
    for (int i = 0; i < 6; i++) begin
      golden = 16'($urandom);
      pulse_start();
      run_wait(i[0], n, se_h, s1_h, s2_h);
      chk("rnd_busy_cycles", n, NBUSY);
      golden = m_misr;
      @(posedge CLOCK);
      #1;
      chk("rnd_pass", pass, 1);
    end

    repeat (2) @(posedge CLOCK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
